// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// mem_arb_pkg : shared widths and FSM encoding for mem_arbiter (rev 1.0)
// ----------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_RESP  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = C_IDLE,
    ISSUE = C_ISSUE,
    RESP  = C_RESP
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// mem_arbiter_if : requester and data-memory buses of mem_arbiter (rev 1.0)
// ----------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int AW = mem_arb_pkg::DEF_AW,
  parameter int DW = mem_arb_pkg::DEF_DW
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, done0, gnt1, done1, rdata,
           mem_read, mem_write, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, done0, gnt1, done1, rdata,
           mem_read, mem_write, mem_addr, mem_wdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------
// rr_arb2 : two-way round-robin pick, favours the requester != last (rev 1.0)
// ----------------------------------------------------------------------
module rr_arb2 (
  input  wire logic [1:0] req_i,
  input  wire logic       last_i,
  output logic            winner_o,
  output logic            any_o
);

  assign any_o    = |req_i;
  assign winner_o = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// mem_arbiter : round-robin IDLE/ISSUE/RESP sequencer for a 1-port memory (rev 1.0)
// ----------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mem_arbiter_if.slave  bus
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic          mem_read_q, mem_read_d, mem_write_q, mem_write_d;

  logic          w_winner;
  logic          w_any;
  logic          w_we_sel;

  rr_arb2 u_rr_arb2 (
    .req_i    ({bus.req1, bus.req0}),
    .last_i   (last_q),
    .winner_o (w_winner),
    .any_o    (w_any)
  );

  assign w_we_sel = w_winner ? bus.we1 : bus.we0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    sel_d       = sel_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          sel_d       = w_winner;
          last_d      = w_winner;
          we_d        = w_we_sel;
          addr_d      = w_winner ? bus.addr1  : bus.addr0;
          wdata_d     = w_winner ? bus.wdata1 : bus.wdata0;
          gnt0_d      = ~w_winner;
          gnt1_d      = w_winner;
          mem_read_d  = ~w_we_sel;
          mem_write_d = w_we_sel;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        done0_d = ~sel_q;
        done1_d = sel_q;
        state_d = RESP;
      end
      RESP: begin
        if (!we_q) rdata_d = bus.mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Memory output is already registered, so read data is forwarded during the done cycle.
  assign bus.rdata     = (state_q == RESP && !we_q) ? bus.mem_rdata : rdata_q;
  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_mem_arbiter : directed self-checking bench with a 256x16 memory model (rev 1.0)
// ----------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.AW(8), .DW(16)) bus ();

  mem_arbiter #(.AW(8), .DW(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: registered read, 1-cycle latency; preloaded while reset is low.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h04] <= 16'h1234;
      mem[8'h08] <= 16'hBEEF;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_read) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl();
    return {25'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1,
            bus.mem_read, bus.mem_write, bus.busy};
  endfunction

  initial begin
    reset      = 1'b0;
    bus.req0   = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1   = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (3) cyc();
    chk("rst_ctl",   ctl(),         32'h0);
    chk("rst_addr",  bus.mem_addr,  32'h0);
    chk("rst_wdata", bus.mem_wdata, 32'h0);
    chk("rst_rdata", bus.rdata,     32'h0);
    reset = 1'b1;

    // req0 write 0x10 <- A5A5
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 16'hA5A5;
    cyc();
    chk("t1_gnt_ctl", ctl(),         32'b1000011);
    chk("t1_addr",    bus.mem_addr,  32'h10);
    chk("t1_wdata",   bus.mem_wdata, 32'hA5A5);
    bus.req0 = 1'b0;
    cyc();
    chk("t1_done_ctl", ctl(),      32'b0010001);
    chk("t1_rdata",    bus.rdata,  32'h0);
    cyc();
    chk("t1_idle", ctl(), 32'h0);

    // req1 read 0x10
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h10;
    cyc();
    chk("t2_gnt_ctl", ctl(),        32'b0100101);
    chk("t2_addr",    bus.mem_addr, 32'h10);
    bus.req1 = 1'b0;
    cyc();
    chk("t2_done_ctl", ctl(),     32'b0001001);
    chk("t2_rdata",    bus.rdata, 32'hA5A5);
    cyc();

    // Top address: req1 write 0xFF <- DEAD, then req0 reads it back
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'hFF; bus.wdata1 = 16'hDEAD;
    cyc();
    chk("ff_wr_ctl",  ctl(),        32'b0100011);
    chk("ff_wr_addr", bus.mem_addr, 32'hFF);
    bus.req1 = 1'b0;
    cyc();
    cyc();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'hFF;
    cyc();
    chk("ff_rd_ctl", ctl(), 32'b1000101);
    bus.req0 = 1'b0;
    cyc();
    chk("ff_rd_done",  ctl(),     32'b0010001);
    chk("ff_rd_rdata", bus.rdata, 32'hDEAD);
    cyc();

    // Preloaded reads 0x04 then 0x08
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
    cyc();
    bus.req0 = 1'b0;
    cyc();
    chk("t4_done0", bus.done0, 32'h1);
    chk("t4_rd04",  bus.rdata, 32'h1234);
    cyc();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h08;
    cyc();
    bus.req1 = 1'b0;
    cyc();
    chk("t4_done1", bus.done1, 32'h1);
    chk("t4_rd08",  bus.rdata, 32'hBEEF);
    cyc();

    // Both requesters held from reset: alternating grants, one per 3 cycles
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h08;
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk($sformatf("t3_gnt_c%0d", i),  {bus.gnt0, bus.gnt1},
          {30'd0, (i % 6) == 1, (i % 6) == 4});
      chk($sformatf("t3_done_c%0d", i), {bus.done0, bus.done1},
          {30'd0, (i % 6) == 2, (i % 6) == 5});
      if (bus.done0) chk("t3_rdata0", bus.rdata, 32'h1234);
      if (bus.done1) chk("t3_rdata1", bus.rdata, 32'hBEEF);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cyc();
    chk("t3_idle", ctl(), 32'h0);

    // Reset during ISSUE of a read
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h04;
    cyc();
    chk("t5_issue", ctl(), 32'b1000101);
    reset    = 1'b0;
    bus.req0 = 1'b0;
    #1;
    chk("t5_rst_ctl",   ctl(),         32'h0);
    chk("t5_rst_addr",  bus.mem_addr,  32'h0);
    chk("t5_rst_rdata", bus.rdata,     32'h0);
    cyc();
    chk("t5_no_done", ctl(), 32'h0);
    reset    = 1'b1;
    bus.req0 = 1'b1;
    cyc();
    chk("t5_regnt", ctl(), 32'b1000101);
    bus.req0 = 1'b0;
    cyc();
    chk("t5_redone", ctl(),     32'b0010001);
    chk("t5_rdata",  bus.rdata, 32'h1234);
    cyc();

    // we toggled during ISSUE is ignored; held req becomes a new write
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h04; bus.wdata1 = 16'h5A5A;
    cyc();
    chk("t6_rd_ctl", ctl(), 32'b0100101);
    bus.we1 = 1'b1;
    cyc();
    chk("t6_rd_done",  ctl(),     32'b0001001);
    chk("t6_rd_rdata", bus.rdata, 32'h1234);
    cyc();
    chk("t6_gap", ctl(), 32'h0);
    cyc();
    chk("t6_wr_ctl",   ctl(),         32'b0100011);
    chk("t6_wr_wdata", bus.mem_wdata, 32'h5A5A);
    bus.req1 = 1'b0;
    cyc();
    chk("t6_wr_done", ctl(),     32'b0001001);
    chk("t6_hold",    bus.rdata, 32'h1234);
    cyc();
    chk("t6_idle", ctl(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
